// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-look-ahead add/subtract unit.
//   cla_seq_state_t : control FSM states (IDLE, RUN, DONE)
//   NIBBLE_W        : width of the shared look-ahead adder slice
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    localparam int NIBBLE_W = 4;

endpackage : cla_seq_pkg

// File: rtl/carry_look_ahead_adder_4bits.sv
// Purely combinational 4-bit carry-look-ahead adder.
//   a, b   : 4-bit addends
//   c_in   : carry into bit 0
//   sum    : 4-bit sum
//   c_out  : carry out of bit 3
// Every carry is expanded from generate/propagate terms, so no carry ripples
// from bit to bit.
module carry_look_ahead_adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    assign c_s[0] = c_in;
    assign c_s[1] = g_s[0] | (p_s[0] & c_in);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_in);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);

    assign sum   = p_s ^ c_s[3:0];
    assign c_out = c_s[4];

endmodule : carry_look_ahead_adder_4bits

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit that reuses one 4-bit carry-look-ahead
// adder, one nibble per cycle, LSB nibble first, with the carry held in a register.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (in_a, in_b, in_sub)
//   out_valid/out_ready   : result handshake (out_sum, out_carry, out_ovf)
// Subtraction is A + ~B + 1: B is inverted at capture and the initial carry is 1.
// out_carry on subtract is 1 when no borrow occurred.
module cla_nibble_serial_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);
    localparam int MSB   = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    // Increment without an adder: bit i toggles when every lower bit is 1.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] upper_ones;
        r = v;
        for (int i = IDX_W - 1; i >= 0; i--) begin
            upper_ones = {IDX_W{1'b1}} << i;
            r[i] = v[i] ^ (&(v | upper_ones));
        end
        return r;
    endfunction

    cla_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    logic [NIBBLE_W-1:0] nib_sum_s;
    logic                nib_cout_s;

    carry_look_ahead_adder_4bits u_cla (
        .a     (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .b     (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .c_in  (carry_q),
        .sum   (nib_sum_s),
        .c_out (nib_cout_s)
    );

    // Next-state logic for the FSM, nibble index, carry and operand/result registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = RUN;
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    idx_d   = {IDX_W{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum_s;
                carry_d = nib_cout_s;
                // idx parks on the last nibble rather than wrapping.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_inc(idx_q);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Outputs come only from registered state; results are masked to zero outside DONE.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? sum_q : {WIDTH{1'b0}};
    assign out_carry = out_valid & carry_q;
    assign out_ovf   = out_valid & (a_q[MSB] == b_q[MSB]) & (sum_q[MSB] != a_q[MSB]);

endmodule : cla_nibble_serial_adder

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];
    vec_t b2b[3];

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present one operand pair at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input string nm);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        chk({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF; in_sub = ~sub;
    endtask

    // Count posedges after the accepting edge until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cyc, k, nacc, nres;
        int acc_cyc[3];
        logic pend;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        b2b[0] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        b2b[1] = '{16'h5555, 16'h1111, 1'b1, 16'h4444, 1'b1, 1'b0};
        b2b[2] = '{16'hC000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset in_ready low", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Table-driven single operations
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            accept(vecs[i].a, vecs[i].b, vecs[i].sub, nm);
            wait_done(lat);
            chk({nm, " latency"}, 32'(lat), 32'd4);
            chk({nm, " sum"}, 32'(out_sum), 32'(vecs[i].sum));
            chk({nm, " carry"}, 32'(out_carry), 32'(vecs[i].carry));
            chk({nm, " ovf"}, 32'(out_ovf), 32'(vecs[i].ovf));
            @(negedge clk);
            chk({nm, " out_valid drops"}, 32'(out_valid), 32'd0);
            chk({nm, " out_sum zero when idle"}, 32'(out_sum), 32'd0);
            chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
        end

        // Backpressure: hold DONE for 5 cycles, in_valid pulses must be ignored
        out_ready = 1'b0;
        accept(16'h1234, 16'h0FCD, 1'b0, "bp");
        wait_done(lat);
        chk("bp latency", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0;
            #1;
            chk($sformatf("bp hold out_valid c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold sum c%0d", c), 32'(out_sum), 32'h2201);
            chk($sformatf("bp hold carry c%0d", c), 32'(out_carry), 32'd0);
            chk($sformatf("bp in_ready low c%0d", c), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp in_ready after release", 32'(in_ready), 32'd1);
        chk("bp out_valid after release", 32'(out_valid), 32'd0);
        repeat (6) @(negedge clk);
        chk("bp no stray accept", 32'(out_valid), 32'd0);

        // Reset while idx = 2
        accept(16'hFFFF, 16'hFFFF, 1'b0, "rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst in_ready while rst_n low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_sum", 32'(out_sum), 32'd0);
        chk("rst in_ready idle", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("rst op discarded", 32'(out_valid), 32'd0);
        accept(16'h0001, 16'h0001, 1'b0, "post-rst");
        wait_done(lat);
        chk("post-rst latency", 32'(lat), 32'd4);
        chk("post-rst sum", 32'(out_sum), 32'h0002);
        chk("post-rst carry", 32'(out_carry), 32'd0);
        chk("post-rst ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);

        // Back-to-back: in_valid held high across three operand sets
        cyc = 0; k = 0; nacc = 0; nres = 0;
        in_a = b2b[0].a; in_b = b2b[0].b; in_sub = b2b[0].sub; in_valid = 1'b1;
        while (nres < 3 && cyc < 60) begin
            pend = in_valid && in_ready;
            if (out_valid) begin
                chk($sformatf("b2b%0d sum", nres), 32'(out_sum), 32'(b2b[nres].sum));
                chk($sformatf("b2b%0d carry", nres), 32'(out_carry), 32'(b2b[nres].carry));
                chk($sformatf("b2b%0d ovf", nres), 32'(out_ovf), 32'(b2b[nres].ovf));
                nres++;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                if (nacc < 3) acc_cyc[nacc] = cyc;
                nacc++;
                k = nacc;
                if (k < 3) begin
                    in_a = b2b[k].a; in_b = b2b[k].b; in_sub = b2b[k].sub;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b result count", 32'(nres), 32'd3);
        chk("b2b accept count", 32'(nacc), 32'd3);
        chk("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        chk("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        repeat (8) @(negedge clk);
        chk("b2b no extra result", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_cla_nibble_serial_adder
